icache_responder: RTL and testbench

ICACHE_RESPONDER -- requirements
Module: icache_responder

---
 rtl/icache_responder_if.sv | 46 ++++
 rtl/icache_responder.sv | 182 ++++++++++++++++++
 tb/tb_icache_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// ---------------------------------------------------------------------------
// icache_responder_if
// Bundles the fetch-side and refill-side signals of the instruction cache.
//   pc_if        fetch byte address (bits [1:0] ignored)
//   instr_if     instruction returned for pc_if (combinational)
//   ready_o      instr_if valid for pc_if; low stalls the fetch stage
//   flush_i      invalidate every line (fence.i)
//   mem_req_o    one-cycle refill request pulse
//   mem_addr_o   line-aligned refill address, held for the whole refill
//   mem_rvalid_i refill beat valid
//   mem_rdata_i  refill beat data, word 0 first
// slave  : the cache side
// master : the fetch stage / memory model side
// ---------------------------------------------------------------------------
interface icache_responder_if;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic        ready_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  pc_if,
        input  flush_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        output instr_if,
        output ready_o,
        output mem_req_o,
        output mem_addr_o
    );

    modport master (
        output pc_if,
        output flush_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        input  instr_if,
        input  ready_o,
        input  mem_req_o,
        input  mem_addr_o
    );
endinterface

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
// Direct-mapped instruction cache with zero-cycle hit latency. A miss latches
// the line address, issues a single request pulse and collects WORDS beats
// before validating the line. Only one refill is ever outstanding.
// Ports:
//   clk    single clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    icache_responder_if.slave (fetch lookup + refill channel)
// Assumes LINES and WORDS are powers of two with WORDS >= 2.
// ---------------------------------------------------------------------------
module icache_responder #(
    parameter int          LINES     = 16,
    parameter int          WORDS     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    icache_responder_if.slave  bus
);

    localparam int WORD_W  = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_LSB = OFF_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } state_e;

    // Control state
    state_e              state_q,   state_d;
    logic [LINES-1:0]    valid_q,   valid_d;
    logic [31:0]         addr_q,    addr_d;
    logic [WORD_W-1:0]   beat_q,    beat_d;
    logic                discard_q, discard_d;

    // Storage (no reset needed: guarded by valid_q)
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [LINES][WORDS];

    // Combinational helpers
    logic [WORD_W-1:0]   pc_word_s;
    logic [IDX_W-1:0]    pc_idx_s;
    logic [TAG_W-1:0]    pc_tag_s;
    logic [IDX_W-1:0]    fill_idx_s;
    logic [TAG_W-1:0]    fill_tag_s;
    logic                hit_s;
    logic                last_beat_s;
    logic                data_we_s;
    logic                tag_we_s;
    logic                ready_s;
    logic [31:0]         instr_s;
    logic                mem_req_s;
    logic [31:0]         mem_addr_s;
    logic                unused_pc_lsb_s;

    // Lookup address split
    assign pc_word_s       = bus.pc_if[OFF_W-1:2];
    assign pc_idx_s        = bus.pc_if[TAG_LSB-1:OFF_W];
    assign pc_tag_s        = bus.pc_if[31:TAG_LSB];
    assign unused_pc_lsb_s = ^bus.pc_if[1:0];

    // Refill target comes from the latched address, never from the live pc
    assign fill_idx_s  = addr_q[TAG_LSB-1:OFF_W];
    assign fill_tag_s  = addr_q[31:TAG_LSB];

    assign hit_s       = valid_q[pc_idx_s] && (tag_q[pc_idx_s] == pc_tag_s);
    assign last_beat_s = (beat_q == WORD_W'(WORDS - 1));

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        discard_d  = discard_q;
        data_we_s  = 1'b0;
        tag_we_s   = 1'b0;
        ready_s    = 1'b0;
        instr_s    = NOP_INSTR;
        mem_req_s  = 1'b0;
        mem_addr_s = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    // Flush cycle stalls fetch; valid bits are cleared below
                    ready_s = 1'b0;
                end else if (hit_s) begin
                    ready_s = 1'b1;
                    instr_s = data_q[pc_idx_s][pc_word_s];
                end else begin
                    addr_d    = {bus.pc_if[31:OFF_W], {OFF_W{1'b0}}};
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_s  = 1'b1;
                mem_addr_s = addr_q;
                beat_d     = {WORD_W{1'b0}};
                state_d    = ST_FILL;
            end
            ST_FILL: begin
                mem_addr_s = addr_q;
                if (bus.mem_rvalid_i) begin
                    data_we_s = 1'b1;
                    beat_d    = beat_q + WORD_W'(1);
                    if (last_beat_s) begin
                        state_d   = ST_IDLE;
                        discard_d = 1'b0;
                        // A flush seen earlier in this refill, or right now,
                        // leaves the line invalid
                        if (!discard_q && !bus.flush_i) begin
                            valid_d[fill_idx_s] = 1'b1;
                            tag_we_s            = 1'b1;
                        end else begin
                            tag_we_s = 1'b0;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    data_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush clears every line in any state; a refill in flight is
        // marked so its completion does not revalidate a stale line
        if (bus.flush_i) begin
            valid_d = {LINES{1'b0}};
            if ((state_q != ST_IDLE) && !(state_q == ST_FILL && bus.mem_rvalid_i && last_beat_s)) begin
                discard_d = 1'b1;
            end else begin
                discard_d = discard_d;
            end
        end else begin
            valid_d = valid_d;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            valid_q   <= {LINES{1'b0}};
            addr_q    <= 32'd0;
            beat_q    <= {WORD_W{1'b0}};
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            discard_q <= discard_d;
        end
    end

    // Tag and data arrays; a beat arriving in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (data_we_s && !reset) begin
            data_q[fill_idx_s][beat_q] <= bus.mem_rdata_i;
        end
        if (tag_we_s && !reset) begin
            tag_q[fill_idx_s] <= fill_tag_s;
        end
    end

    assign bus.ready_o    = ready_s;
    assign bus.instr_if   = instr_s;
    assign bus.mem_req_o  = mem_req_s;
    assign bus.mem_addr_o = mem_addr_s;

endmodule

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
// Directed vectors for icache_responder. Each stimulus cycle pushes the
// hand-computed expected outputs into a scoreboard queue; a monitor on the
// falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_icache_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        ready;
        logic [31:0] instr;
        logic        req;
        logic [31:0] addr;
        logic [15:0] id;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    icache_responder_if bus_if ();

    icache_responder #(
        .LINES     (16),
        .WORDS     (4),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;

    // One stimulus cycle with its expected outputs
    task automatic drive(input logic rst, input logic [31:0] pc, input logic fl,
                         input logic rv, input logic [31:0] rd,
                         input logic er, input logic [31:0] ei,
                         input logic eq, input logic [31:0] ea);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = rst;
        bus_if.pc_if        = pc;
        bus_if.flush_i      = fl;
        bus_if.mem_rvalid_i = rv;
        bus_if.mem_rdata_i  = rd;
        vid++;
        e.ready = er;
        e.instr = ei;
        e.req   = eq;
        e.addr  = ea;
        e.id    = vid[15:0];
        sb.push_back(e);
    endtask

    task automatic look(input logic [31:0] pc, input logic er, input logic [31:0] ei);
        drive(1'b0, pc, 1'b0, 1'b0, 32'd0, er, ei, 1'b0, 32'd0);
    endtask

    // Miss cycle in IDLE followed by the request cycle
    task automatic miss(input logic [31:0] pc);
        logic [31:0] la;
        la = {pc[31:4], 4'h0};
        drive(1'b0, pc, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);
        drive(1'b0, pc, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b1, la);
    endtask

    task automatic beat(input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                        input logic fl, input logic [31:0] la);
        drive(1'b0, pc, fl, rv, rd, 1'b0, NOP, 1'b0, la);
    endtask

    task automatic fill4(input logic [31:0] pc, input logic [31:0] base, input logic [31:0] la);
        for (int k = 0; k < 4; k++) begin
            beat(pc, 1'b1, base + 32'(k), 1'b0, la);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (bus_if.ready_o !== mon_e.ready || bus_if.instr_if !== mon_e.instr ||
                bus_if.mem_req_o !== mon_e.req || bus_if.mem_addr_o !== mon_e.addr) begin
                n_bad++;
                $display("FAIL vec%0d: got ready=%b instr=%h req=%b addr=%h, want ready=%b instr=%h req=%b addr=%h",
                         mon_e.id, bus_if.ready_o, bus_if.instr_if, bus_if.mem_req_o, bus_if.mem_addr_o,
                         mon_e.ready, mon_e.instr, mon_e.req, mon_e.addr);
            end
        end
    end

    initial begin
        bus_if.pc_if        = 32'h0000_0100;
        bus_if.flush_i      = 1'b0;
        bus_if.mem_rvalid_i = 1'b0;
        bus_if.mem_rdata_i  = 32'd0;

        // Reset state
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);

        // Cold miss
        miss(32'h100);
        fill4(32'h100, 32'hA000_0000, 32'h100);
        look(32'h100, 1'b1, 32'hA000_0000);
        look(32'h10C, 1'b1, 32'hA000_0003);
        look(32'h104, 1'b1, 32'hA000_0001);

        // Conflict on index 0
        miss(32'h200);
        fill4(32'h200, 32'hB000_0000, 32'h200);
        look(32'h208, 1'b1, 32'hB000_0002);
        // 0x100 misses again; stray beat during REQ is ignored
        drive(1'b0, 32'h100, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);
        drive(1'b0, 32'h100, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, NOP, 1'b1, 32'h100);

        // Gapped beats 1,0,0,1,1,0,1
        beat(32'h100, 1'b1, 32'hC000_0000, 1'b0, 32'h100);
        beat(32'h100, 1'b0, 32'h5555_5555, 1'b0, 32'h100);
        beat(32'h100, 1'b0, 32'h5555_5555, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'hC000_0001, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'hC000_0002, 1'b0, 32'h100);
        beat(32'h100, 1'b0, 32'h5555_5555, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'hC000_0003, 1'b0, 32'h100);
        look(32'h100, 1'b1, 32'hC000_0000);
        // Stray beat in IDLE must not write
        drive(1'b0, 32'h104, 1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 32'hC000_0001, 1'b0, 32'd0);
        look(32'h104, 1'b1, 32'hC000_0001);
        look(32'h10C, 1'b1, 32'hC000_0003);
        look(32'h108, 1'b1, 32'hC000_0002);

        // Second valid line at index 4
        miss(32'h340);
        fill4(32'h340, 32'hD000_0000, 32'h340);
        look(32'h340, 1'b1, 32'hD000_0000);
        look(32'h100, 1'b1, 32'hC000_0000);

        // Flush in IDLE, then both lines miss
        drive(1'b0, 32'h340, 1'b1, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);
        miss(32'h100);
        beat(32'h100, 1'b1, 32'hE000_0000, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'hE000_0001, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'hE000_0002, 1'b0, 32'h100);
        // Flush on the last beat wins
        beat(32'h100, 1'b1, 32'hE000_0003, 1'b1, 32'h100);
        miss(32'h100);
        fill4(32'h100, 32'hF000_0000, 32'h100);
        look(32'h100, 1'b1, 32'hF000_0000);
        miss(32'h340);

        // Reset after two beats abandons the refill
        beat(32'h340, 1'b1, 32'h6000_0000, 1'b0, 32'h340);
        beat(32'h340, 1'b1, 32'h6000_0001, 1'b0, 32'h340);
        drive(1'b1, 32'h340, 1'b0, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'h340);
        drive(1'b0, 32'h340, 1'b0, 1'b1, 32'hBAD0_0002, 1'b0, NOP, 1'b0, 32'd0);
        drive(1'b0, 32'h340, 1'b0, 1'b1, 32'hBAD0_0003, 1'b0, NOP, 1'b1, 32'h340);
        fill4(32'h340, 32'h4000_0000, 32'h340);
        look(32'h344, 1'b1, 32'h4000_0001);
        look(32'h34C, 1'b1, 32'h4000_0003);

        // Redirect mid-refill
        drive(1'b0, 32'h100, 1'b1, 1'b0, 32'd0, 1'b0, NOP, 1'b0, 32'd0);
        miss(32'h100);
        beat(32'h100, 1'b1, 32'h7000_0000, 1'b0, 32'h100);
        beat(32'h100, 1'b1, 32'h7000_0001, 1'b0, 32'h100);
        beat(32'h340, 1'b1, 32'h7000_0002, 1'b0, 32'h100);
        beat(32'h340, 1'b1, 32'h7000_0003, 1'b0, 32'h100);
        miss(32'h340);
        fill4(32'h340, 32'h5000_0000, 32'h340);
        look(32'h340, 1'b1, 32'h5000_0000);
        look(32'h108, 1'b1, 32'h7000_0002);

        // Drain the scoreboard
        @(posedge clk);
        #1;
        bus_if.mem_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
